// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receive controller.
//   Bus addresses of the data and status/control registers, status and
//   control bit positions, and the bus handshake state type.
package uart_pkg;

    localparam logic [31:0] UART_ADDR_DATA = 32'hf000_0000;
    localparam logic [31:0] UART_ADDR_CTL  = 32'hf000_0004;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTL_CLR_OVR = 2;
    localparam int CTL_CLR_FE  = 3;
    localparam int CTL_FLUSH   = 4;

    localparam logic [31:0] RDATA_EMPTY = 32'h8000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rx_bus_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; a push on a full FIFO is accepted
//   when a pop happens in the same cycle.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request and data (dropped when full without a pop)
//   pop, dout  : read request; dout shows the head combinationally
//   flush      : empties the FIFO; overrides a same-cycle push and pop
//   count      : occupancy, full, empty : occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop  ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: memory-mapped UART receive controller with byte FIFO.
//   clk, rst             : clock, synchronous active-high reset
//   received, rx_byte    : byte-valid pulse and byte from the uart core
//   recv_error           : framing-error pulse from the uart core
//   mem_valid/addr/wdata/wstrb : CPU bus request (wstrb 1111 write, 0000 read)
//   mem_ready, mem_rdata : one-cycle acknowledge and registered read data
//   rx_not_empty         : FIFO holds at least one byte
module uart_rx_controller import uart_pkg::*; #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] ADDR_DATA = UART_ADDR_DATA,
    parameter logic [31:0] ADDR_CTL  = UART_ADDR_CTL
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        rx_not_empty
);

    localparam int CW = $clog2(DEPTH+1);

    rx_bus_state_t state;
    rx_bus_state_t state_next;

    logic [7:0]    head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          sel_data;
    logic          sel_ctl;
    logic          sel;
    logic          is_rd;
    logic          is_wr;
    logic          accept;
    logic          pop;
    logic          ctl_wr;
    logic          flush;
    logic          clr_ovr;
    logic          clr_fe;
    logic          ovr_set;
    logic          overrun;
    logic          frame_err;
    logic [31:0]   status;
    logic [31:0]   rdata_next;
    logic [31:0]   rdata_q;
    logic          unused_wdata;

    assign unused_wdata = ^{mem_wdata[31:5], mem_wdata[1:0]};

    assign sel_data = mem_addr == ADDR_DATA;
    assign sel_ctl  = mem_addr == ADDR_CTL;
    assign sel      = mem_valid && (sel_data || sel_ctl);
    assign is_rd    = mem_wstrb == 4'b0000;
    assign is_wr    = mem_wstrb == 4'b1111;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (received),
        .pop   (pop),
        .flush (flush),
        .din   (rx_byte),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end

    // mem_valid is ignored in ACK: the CPU drops it on the acknowledge edge.
    always_comb begin
        state_next = (state == IDLE && sel) ? ACK : IDLE;
    end

    always_comb begin
        accept  = state == IDLE && sel;
        pop     = accept && sel_data && is_rd && !empty;
        ctl_wr  = accept && sel_ctl && is_wr;
        flush   = ctl_wr && mem_wdata[CTL_FLUSH];
        clr_ovr = ctl_wr && mem_wdata[CTL_CLR_OVR];
        clr_fe  = ctl_wr && mem_wdata[CTL_CLR_FE];
        status  = '0;
        status[ST_NOT_EMPTY]         = !empty;
        status[ST_FULL]              = full;
        status[ST_OVERRUN]           = overrun;
        status[ST_FRAME_ERR]         = frame_err;
        status[ST_COUNT_LSB +: 8]    = 8'(count);
        rdata_next = !accept || !is_rd ? 32'h0 :
                     sel_ctl           ? status :
                     empty             ? RDATA_EMPTY : {24'h0, head};
    end

    // A byte arriving on a full FIFO is lost unless a same-cycle pop frees a
    // slot; a same-cycle flush discards it silently instead.
    assign ovr_set = received && full && !pop && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q   <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rdata_q   <= rdata_next;
            overrun   <= ovr_set ? 1'b1 : clr_ovr ? 1'b0 : overrun;
            frame_err <= recv_error ? 1'b1 : clr_fe ? 1'b0 : frame_err;
        end
    end

    assign mem_ready    = state == ACK;
    assign mem_rdata    = rdata_q;
    assign rx_not_empty = !empty;

endmodule
